// File: rtl/status_flag_pkg.sv
// Shared encodings for the status flag unit:
// op_class values, {N,Z,C,V} bit indices, flag width.
package status_flag_pkg;

  localparam int FLAG_W = 4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_ADD   = 2'd1,
    OP_SUB   = 2'd2,
    OP_LOGIC = 2'd3
  } op_class_e;

endpackage

// File: rtl/flag_stack.sv
// LIFO of saved {N,Z,C,V} flags; ignores overflow,
// underflow and push+pop. Ports: clock, reset,
// push, pop, wdata, rdata (top entry), full, empty.
module flag_stack
  import status_flag_pkg::*;
#(
  parameter int STACK_DEPTH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] wdata,
  output logic [FLAG_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(STACK_DEPTH);
  localparam logic [AW:0] FULL_CNT =
    (AW+1)'(STACK_DEPTH);

  logic [FLAG_W-1:0] r_mem [STACK_DEPTH];
  logic [AW:0]       r_count;
  logic              r_full;
  logic              r_empty;
  logic [AW:0]       w_count_nxt;
  logic              w_push_ok;
  logic              w_pop_ok;
  logic [AW-1:0]     w_top_idx;

  assign w_push_ok = push & ~pop & ~r_full;
  assign w_pop_ok  = pop & ~push & ~r_empty;

  // Top entry sits one below the count.
  assign w_top_idx = AW'(r_count - 1'b1);
  assign rdata     = r_mem[w_top_idx];

  always_comb begin
    w_count_nxt = r_count;
    unique case (1'b1)
      w_push_ok: w_count_nxt = r_count + 1'b1;
      w_pop_ok:  w_count_nxt = r_count - 1'b1;
      default:   w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == FULL_CNT);
      r_empty <= (w_count_nxt == '0);
    end
  end

  always_ff @(posedge clock) begin
    if (!reset && w_push_ok)
      r_mem[AW'(r_count)] <= wdata;
  end

  assign full  = r_full;
  assign empty = r_empty;

endmodule

// File: rtl/status_flag_unit.sv
// Registered N/Z/C/V flags from ALU result, MSR-style
// writes, optional save/restore stack (FLAG_STACK_EN).
// Ports: clock, reset, result, op_a_msb, op_b_msb,
// alu_carry, shift_carry, op_class, update, flag_wr,
// flag_wdata, push, pop -> Neg, Zer, Carry, V,
// stack_full, stack_empty, stack_err.
module status_flag_unit
  import status_flag_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int STACK_DEPTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] result,
  input  logic                  op_a_msb,
  input  logic                  op_b_msb,
  input  logic                  alu_carry,
  input  logic                  shift_carry,
  input  logic [1:0]            op_class,
  input  logic                  update,
  input  logic                  flag_wr,
  input  logic [FLAG_W-1:0]     flag_wdata,
  input  logic                  push,
  input  logic                  pop,
  output logic                  Neg,
  output logic                  Zer,
  output logic                  Carry,
  output logic                  V,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_err
);

  logic [FLAG_W-1:0] r_flags;
  logic [FLAG_W-1:0] w_calc;
  logic [FLAG_W-1:0] w_next;
  logic [FLAG_W-1:0] w_pop_data;
  logic              w_pop_ok;
  logic              w_res_msb;
  logic              w_res_zero;

  assign w_res_msb  = result[DATA_WIDTH-1];
  assign w_res_zero = (result == '0);

  always_comb begin
    w_calc = r_flags;
    unique case (1'b1)
      (op_class == OP_ADD): begin
        w_calc[FLAG_N] = w_res_msb;
        w_calc[FLAG_Z] = w_res_zero;
        w_calc[FLAG_C] = alu_carry;
        w_calc[FLAG_V] = (op_a_msb == op_b_msb) &&
                         (w_res_msb != op_a_msb);
      end
      (op_class == OP_SUB): begin
        w_calc[FLAG_N] = w_res_msb;
        w_calc[FLAG_Z] = w_res_zero;
        w_calc[FLAG_C] = alu_carry;
        w_calc[FLAG_V] = (op_a_msb != op_b_msb) &&
                         (w_res_msb != op_a_msb);
      end
      (op_class == OP_LOGIC): begin
        w_calc[FLAG_N] = w_res_msb;
        w_calc[FLAG_Z] = w_res_zero;
        w_calc[FLAG_C] = shift_carry;
      end
      default: w_calc = r_flags;
    endcase
  end

  always_comb begin
    w_next = r_flags;
    if (w_pop_ok)
      w_next = w_pop_data;
    else if (flag_wr)
      w_next = flag_wdata;
    else if (update)
      w_next = w_calc;
  end

  always_ff @(posedge clock) begin
    if (reset) r_flags <= '0;
    else       r_flags <= w_next;
  end

`ifdef FLAG_STACK_EN
  logic w_full;
  logic w_empty;
  logic r_err;

  // Push saves r_flags, i.e. the pre-write value.
  flag_stack #(
    .STACK_DEPTH(STACK_DEPTH)
  ) u_stack (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (r_flags),
    .rdata (w_pop_data),
    .full  (w_full),
    .empty (w_empty)
  );

  assign w_pop_ok = pop & ~push & ~w_empty;

  always_ff @(posedge clock) begin
    if (reset)
      r_err <= 1'b0;
    else if ((push & pop) | (push & w_full) |
             (pop & w_empty))
      r_err <= 1'b1;
  end

  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign stack_err   = r_err;
`else
  logic w_unused_stack;

  assign w_unused_stack = push ^ pop;
  assign w_pop_ok       = 1'b0;
  assign w_pop_data     = '0;
  assign stack_full     = 1'b0;
  assign stack_empty    = 1'b1;
  assign stack_err      = 1'b0;
`endif

  assign Neg   = r_flags[FLAG_N];
  assign Zer   = r_flags[FLAG_Z];
  assign Carry = r_flags[FLAG_C];
  assign V     = r_flags[FLAG_V];

endmodule

// File: tb/tb_status_flag_unit.sv
// Directed bench for status_flag_unit: vector table
// for flag math, hand sequences for stack and reset.
module tb_status_flag_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] result;
  logic        op_a_msb, op_b_msb;
  logic        alu_carry, shift_carry;
  logic [1:0]  op_class;
  logic        update, flag_wr;
  logic [3:0]  flag_wdata;
  logic        push, pop;
  logic        Neg, Zer, Carry, V;
  logic        stack_full, stack_empty, stack_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  status_flag_unit #(
    .DATA_WIDTH(32),
    .STACK_DEPTH(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .result      (result),
    .op_a_msb    (op_a_msb),
    .op_b_msb    (op_b_msb),
    .alu_carry   (alu_carry),
    .shift_carry (shift_carry),
    .op_class    (op_class),
    .update      (update),
    .flag_wr     (flag_wr),
    .flag_wdata  (flag_wdata),
    .push        (push),
    .pop         (pop),
    .Neg         (Neg),
    .Zer         (Zer),
    .Carry       (Carry),
    .V           (V),
    .stack_full  (stack_full),
    .stack_empty (stack_empty),
    .stack_err   (stack_err)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] res;
    logic        a, b, ac, sc;
    logic        upd, wr;
    logic [3:0]  wd;
    logic [3:0]  exp;
  } vec_t;

  vec_t vecs [13];

  function automatic logic [3:0] flags();
    return {Neg, Zer, Carry, V};
  endfunction

  task automatic check(input string name,
                       input logic [3:0] act,
                       input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b",
               name, act, exp);
    end
  endtask

  task automatic idle();
    reset = 0; result = '0; op_class = 2'd0;
    op_a_msb = 0; op_b_msb = 0;
    alu_carry = 0; shift_carry = 0;
    update = 0; flag_wr = 0; flag_wdata = '0;
    push = 0; pop = 0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wr(input logic [3:0] v);
    idle(); flag_wr = 1; flag_wdata = v;
    tick();
  endtask

  task automatic chk_stat(input string name,
                          input logic f,
                          input logic e,
                          input logic er);
    check(name, {1'b0, stack_full, stack_empty,
                 stack_err}, {1'b0, f, e, er});
  endtask

  initial begin
    // op, res, a, b, ac, sc, upd, wr, wd, exp
    vecs[0]  = '{2'd0, 32'h0, 0,0,0,0, 0,1, 4'b0000, 4'b0000};
    vecs[1]  = '{2'd1, 32'h0, 1,1,1,0, 1,0, 4'b0000, 4'b0111};
    vecs[2]  = '{2'd2, 32'h80000000, 0,1,0,0, 1,0, 4'b0000, 4'b1001};
    vecs[3]  = '{2'd0, 32'h0, 0,0,0,0, 0,1, 4'b0011, 4'b0011};
    vecs[4]  = '{2'd3, 32'h5, 0,0,0,0, 1,0, 4'b0000, 4'b0001};
    vecs[5]  = '{2'd0, 32'h0, 0,0,1,1, 1,0, 4'b0000, 4'b0001};
    vecs[6]  = '{2'd1, 32'h0, 0,0,1,0, 0,0, 4'b0000, 4'b0001};
    vecs[7]  = '{2'd1, 32'h0, 1,1,1,0, 1,1, 4'b1110, 4'b1110};
    vecs[8]  = '{2'd1, 32'h7fffffff, 0,0,0,0, 1,0, 4'b0000, 4'b0000};
    vecs[9]  = '{2'd1, 32'h80000000, 0,0,0,0, 1,0, 4'b0000, 4'b1001};
    vecs[10] = '{2'd2, 32'hffffffff, 1,1,0,0, 1,0, 4'b0000, 4'b1000};
    vecs[11] = '{2'd3, 32'h0, 0,0,0,1, 1,0, 4'b0000, 4'b0110};
    vecs[12] = '{2'd2, 32'h1, 1,0,1,0, 1,0, 4'b0000, 4'b0011};

    idle();
    reset = 1;
    tick();
    tick();
    check("reset_flags", flags(), 4'b0000);
    chk_stat("reset_stat", 0, 1, 0);

    for (int i = 0; i < 13; i++) begin
      idle();
      op_class = vecs[i].op;
      result = vecs[i].res;
      op_a_msb = vecs[i].a;
      op_b_msb = vecs[i].b;
      alu_carry = vecs[i].ac;
      shift_carry = vecs[i].sc;
      update = vecs[i].upd;
      flag_wr = vecs[i].wr;
      flag_wdata = vecs[i].wd;
      tick();
      check($sformatf("vec%0d", i), flags(),
            vecs[i].exp);
    end

`ifdef FLAG_STACK_EN
    // Push saves pre-write flags; pop restores them.
    wr(4'b1010);
    check("pre_push", flags(), 4'b1010);
    idle(); push = 1; flag_wr = 1; flag_wdata = 4'b0101;
    tick();
    check("push_wr", flags(), 4'b0101);
    chk_stat("push_stat", 0, 0, 0);
    idle(); pop = 1;
    tick();
    check("pop_restore", flags(), 4'b1010);
    chk_stat("pop_stat", 0, 1, 0);

    // Fill to overflow.
    idle(); reset = 1; tick();
    for (int i = 0; i < 5; i++) begin
      idle(); push = 1; flag_wr = 1;
      flag_wdata = 4'(i + 1);
      tick();
      if (i == 3) chk_stat("full4", 1, 0, 0);
    end
    check("ovf_flags", flags(), 4'b0101);
    chk_stat("ovf_stat", 1, 0, 1);
    for (int i = 0; i < 4; i++) begin
      idle(); pop = 1; flag_wr = 1;
      flag_wdata = 4'b1111;
      tick();
      check($sformatf("pop%0d", i), flags(),
            4'(3 - i));
      if (i == 0) chk_stat("pop0_stat", 0, 0, 1);
    end
    chk_stat("drain_stat", 0, 1, 1);
    idle(); pop = 1; flag_wr = 1;
    flag_wdata = 4'b1100;
    tick();
    check("underflow_wr", flags(), 4'b1100);
    chk_stat("underflow_stat", 0, 1, 1);

    // Simultaneous push and pop.
    idle(); reset = 1; tick();
    wr(4'b0110);
    idle(); push = 1; pop = 1;
    tick();
    chk_stat("pushpop_stat", 0, 1, 1);
    check("pushpop_flags", flags(), 4'b0110);

    // Reset beats update and push.
    wr(4'b1111);
    idle(); push = 1; tick();
    chk_stat("pre_rst", 0, 0, 1);
`else
    wr(4'b1010);
    idle(); push = 1; flag_wr = 1; flag_wdata = 4'b0101;
    tick();
    check("nostk_push", flags(), 4'b0101);
    chk_stat("nostk_push_stat", 0, 1, 0);
    idle(); pop = 1;
    tick();
    check("nostk_pop", flags(), 4'b0101);
    chk_stat("nostk_pop_stat", 0, 1, 0);
    wr(4'b1111);
`endif

    idle();
    reset = 1; update = 1; op_class = 2'd1;
    result = 32'h80000000; alu_carry = 1;
    push = 1;
    tick();
    check("rst_prio_flags", flags(), 4'b0000);
    chk_stat("rst_prio_stat", 0, 1, 0);
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
